// File: rtl/uart_rx_word.sv
// uart_rx_word: 16x-oversampled UART receiver delivering one DBIT-wide word per frame
module uart_rx_word #(
    parameter int DBIT    = 16,
    parameter int SB_TICK = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    input  logic            i_s_tick,
    output logic [DBIT-1:0] o_dout,
    output logic            o_rx_done_tick,
    output logic            o_frame_err,
    output logic            o_busy
);
    localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t          state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] b;
    logic [1:0]      sync;
    logic            rx_s;
    assign rx_s = sync[1];
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync           <= 2'b11;
            state          <= IDLE;
            s              <= '0;
            n              <= '0;
            b              <= '0;
            o_dout         <= '0;
            o_rx_done_tick <= 1'b0;
            o_frame_err    <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            sync           <= {sync[0], i_rx};
            o_rx_done_tick <= 1'b0;
            case (state)
                IDLE: if (!rx_s) begin
                    state  <= START;
                    s      <= '0;
                    o_busy <= 1'b1;
                end
                START: if (i_s_tick) begin
                    if (s == SW'(7)) begin
                        if (!rx_s) begin
                            state <= DATA;
                            s     <= '0;
                            n     <= '0;
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end else
                        s <= s + SW'(1);
                end
                DATA: if (i_s_tick) begin
                    if (s == SW'(15)) begin
                        s <= '0;
                        b <= {rx_s, b[DBIT-1:1]};
                        if (n == NW'(DBIT - 1))
                            state <= STOP;
                        else
                            n <= n + NW'(1);
                    end else
                        s <= s + SW'(1);
                end
                STOP: if (i_s_tick) begin
                    if (s == SW'(SB_TICK - 1)) begin
                        o_dout         <= b;
                        o_frame_err    <= ~rx_s;
                        o_rx_done_tick <= 1'b1;
                        o_busy         <= 1'b0;
                        state          <= IDLE;
                    end else
                        s <= s + SW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word: frame-level scoreboard bench for uart_rx_word
module tb_uart_rx_word;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        tick = 1'b0;
    logic [15:0] dout;
    logic        done, ferr, busy;
    int          div = 4;
    int          cnt = 0;
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    logic        prev_done = 1'b0;
    logic [15:0] last_dout = '0;

    typedef struct {logic [15:0] data; logic err;} exp_t;
    typedef struct {int dv; logic [15:0] data; logic stop_ok; logic [15:0] exp_dout; logic exp_err;} vec_t;
    exp_t expq[$];
    exp_t e;
    vec_t vecs[6];

    uart_rx_word #(.DBIT(16), .SB_TICK(16)) dut (
        .i_clk(clk), .i_reset(rst), .i_rx(rx), .i_s_tick(tick),
        .o_dout(dout), .o_rx_done_tick(done), .o_frame_err(ferr), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // mod_m_counter model: one-clock tick every div clocks
    always @(posedge clk) begin
        if (cnt >= div - 1) begin
            cnt  <= 0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1;
            tick <= 1'b0;
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // every done pulse is matched against the oldest frame still owed
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got pulse with dout %0h, want none", dout);
            end else begin
                e = expq.pop_front();
                check("dout", dout, e.data);
                check("frame_err", ferr, e.err);
                check("busy_at_done", busy, 0);
            end
            if (prev_done) begin
                total++;
                bad++;
                $display("FAIL done_width: got pulse of 2+ cycles, want 1");
            end
        end
        prev_done <= done;
    end

    task automatic bit_hold(logic v, int ticks);
        rx = v;
        repeat (ticks * div) @(negedge clk);
    endtask

    // a bad stop is held low only past mid-bit so the line is high again before a new start sample
    task automatic send(logic [15:0] d, logic stop_ok);
        @(negedge clk);
        bit_hold(1'b0, 16);
        for (int i = 0; i < 16; i++) bit_hold(d[i], 16);
        if (stop_ok) bit_hold(1'b1, 16);
        else begin
            bit_hold(1'b0, 10);
            bit_hold(1'b1, 22);
        end
    endtask

    task automatic expect_frame(logic [15:0] d, logic err);
        exp_t x;
        x.data = d;
        x.err = err;
        expq.push_back(x);
        last_dout = d;
    endtask

    task automatic wait_done(int target, int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done_cnt >= target, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int          target;
        int          gap;
        logic [15:0] w;
        logic [15:0] d;
        logic        ok;
        vecs[0] = '{33, 16'hA5C3, 1'b1, 16'hA5C3, 1'b0};
        vecs[1] = '{4,  16'h1234, 1'b0, 16'h1234, 1'b1};
        vecs[2] = '{4,  16'h5678, 1'b1, 16'h5678, 1'b0};
        vecs[3] = '{3,  16'h0000, 1'b1, 16'h0000, 1'b0};
        vecs[4] = '{2,  16'hFFFF, 1'b1, 16'hFFFF, 1'b0};
        vecs[5] = '{4,  16'h8001, 1'b0, 16'h8001, 1'b1};
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_err", ferr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            div = vecs[i].dv;
            repeat (16 * div) @(negedge clk);
            expect_frame(vecs[i].exp_dout, vecs[i].exp_err);
            target = done_cnt + 1;
            send(vecs[i].data, vecs[i].stop_ok);
            wait_done(target, 40 * 16 * div);
            repeat (16 * div) @(negedge clk);
            check("busy_idle", busy, 0);
        end

        div = 4;
        expect_frame(16'h0001, 1'b0);
        expect_frame(16'hFFFF, 1'b0);
        target = done_cnt + 2;
        send(16'h0001, 1'b1);
        send(16'hFFFF, 1'b1);
        wait_done(target, 40 * 16 * div);
        repeat (16 * div) @(negedge clk);
        check("b2b_busy_idle", busy, 0);

        target = done_cnt;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch_busy_high", busy, 1);
        repeat (3 * div - 5) @(negedge clk);
        rx = 1'b1;
        repeat (32 * div) @(negedge clk);
        check("glitch_busy_low", busy, 0);
        check("glitch_dout_held", dout, last_dout);
        check("glitch_no_done", done_cnt, target);

        w = 16'hBEEF;
        target = done_cnt;
        @(negedge clk);
        bit_hold(1'b0, 16);
        for (int i = 0; i < 7; i++) bit_hold(w[i], 16);
        rx = 1'b1;
        repeat (8 * div) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (48 * div) @(negedge clk);
        check("abort_dout", dout, 0);
        check("abort_err", ferr, 0);
        check("abort_busy", busy, 0);
        check("abort_no_done", done_cnt, target);
        expect_frame(16'h00FF, 1'b0);
        target = done_cnt + 1;
        send(16'h00FF, 1'b1);
        wait_done(target, 40 * 16 * div);

        for (int i = 0; i < 16; i++) begin
            div = $urandom_range(2, 4);
            d = 16'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            expect_frame(d, ~ok);
            target = done_cnt + 1;
            send(d, ok);
            wait_done(target, 40 * 16 * div);
            gap = $urandom_range(0, 1);
            repeat (gap * 16 * div) @(negedge clk);
        end
        repeat (32 * div) @(negedge clk);
        check("rand_busy_idle", busy, 0);
        check("queue_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_word.md
# uart_rx_word

Serial receiver that is the far end of the 16-bit `uart_tx` link. It recovers one DBIT-wide word per frame from the serial line, which carries the BIP accumulator. It oversamples `i_rx` using the same `mod_m_counter` baud tick that `uart_tx` uses (SB_TICK ticks per bit, DIV=33 at 10 MHz for 19200 baud). It presents each received word with a one-cycle done strobe and a framing-error flag, so the host side or a loopback bench can capture `o_ACC` values sent after `o_Halt`.

## Interface
- `DBIT`, default 16: data bits per frame, LSB first, no parity.
- `SB_TICK`, default 16: ticks for the stop-bit interval. 16 = 1 stop bit, 32 = 2 stop bits.
- `i_clk`  input  1  system clock; all logic on rising edge.
- `i_reset`  input  1  synchronous, active-high reset.
- `i_rx`  input  1  serial line, idle high, asynchronous to `i_clk`.
- `i_s_tick`  input  1  oversampling tick (16 per bit), one `i_clk` wide, from `mod_m_counter`.
- `o_dout`  output  DBIT  last received word; holds until the next frame completes.
- `o_rx_done_tick`  output  1  one-cycle pulse when `o_dout` and `o_frame_err` are updated.
- `o_frame_err`  output  1  1 if the stop sample of the last frame was 0; held until the next done.
- `o_busy`  output  1  1 whenever the FSM is not in IDLE.

## Operation
- Synchronizer:
  - `i_rx` passes through 2 flops, both reset to 1.
  - The FSM sees only the synchronized value `rx_s`.
- Registers:
  - state (IDLE, START, DATA, STOP).
  - tick counter `s` (4 bits; widened to hold SB_TICK-1).
  - bit counter `n` (width clog2(DBIT)).
  - shift register `b` (DBIT).
  - output holding registers.
- IDLE:
  - If `rx_s`==0, go to START with `s`=0.
  - No tick is needed to leave IDLE.
- START: only on ticks.
  - If `s`==7 (mid start bit): if `rx_s`==0, go to DATA with `s`=0, `n`=0. Otherwise the low pulse was a glitch; return to IDLE with no output change.
  - Otherwise `s`++.
- DATA: only on ticks.
  - If `s`==15: set `s`=0 and `b`={`rx_s`, `b`[DBIT-1:1]} (LSB first). If `n`==DBIT-1 go to STOP, else `n`++.
  - Otherwise `s`++.
- STOP: only on ticks.
  - If `s`==SB_TICK-1 (mid of last stop bit): `o_dout`<=`b`, `o_frame_err`<=~`rx_s`, `o_rx_done_tick`<=1, go to IDLE.
  - Otherwise `s`++.
- Framing error:
  - Data is still delivered; the flag marks it.
  - If the line stays low after a framing error (break), IDLE immediately sees `rx_s`==0 and starts a new frame attempt. This is the required behaviour.
- Reset values:
  - state=IDLE; `s`=0, `n`=0, `b`=0.
  - `o_dout`=0, `o_rx_done_tick`=0, `o_frame_err`=0, `o_busy`=0.
  - Synchronizer flops=1.
- Reset mid-frame aborts the frame: no done pulse, `o_dout` cleared.
- Ticks arriving while in IDLE are ignored.

## Timing
- `o_rx_done_tick` is registered. It is high for exactly the one `i_clk` cycle after the STOP-completing tick.
- `o_dout`/`o_frame_err` change in the same cycle the pulse rises.
- Frame recognition latency from the falling edge on `i_rx`:
  - 2 clocks for the synchronizer, plus 1 clock into START, plus 8 ticks to mid start bit.
  - Each data bit is sampled 16 ticks after the previous one.
  - Done follows DBIT×16 + SB_TICK ticks after mid start bit.
- With DIV=33, one bit is 528 clocks and a full 16-bit frame with 1 stop bit is about 18×528 clocks.
- `o_busy` rises the cycle after `rx_s` falls in IDLE. It falls in the same cycle `o_rx_done_tick` rises, or on a glitch return to IDLE.
- The receiver tolerates `uart_tx` starting the next frame's start bit immediately after the stop bit. Back-to-back frames must not be lost.

## Test plan
- Single word: drive 0xA5C3 LSB first with correct framing at 528 clocks/bit, `i_s_tick` from `mod_m_counter` (M=33) -> one done pulse, `o_dout`=0xA5C3, `o_frame_err`=0, `o_busy` low afterwards.
- Back-to-back: 0x0001 then 0xFFFF with no idle gap -> two done pulses, values in order, both `o_frame_err`=0.
- Glitch: `i_rx` low for 3 tick periods then high -> no done pulse, `o_busy` returns to 0, `o_dout` unchanged.
- Framing error: send 0x1234 with the stop bit driven 0 -> done pulse, `o_dout`=0x1234, `o_frame_err`=1. The next good frame 0x5678 clears the flag.
- Reset mid-frame: assert `i_reset` for 1 clock during data bit 7 of 0xBEEF, release with the line high -> no done pulse. All outputs read 0. The next frame 0x00FF is received correctly.
- Loopback: `uart_tx`(DBIT=16) to `uart_rx_word` sharing one `mod_m_counter`, with BIP running to `o_Halt` and `i_din`=`o_ACC` -> `o_dout` equals `o_ACC`, `o_frame_err`=0.
